// File: rtl/pc_gen_ras_if.sv
// Fetch-side handshake between the branch predictor / recovery logic and
// the PC generator with its return-address stack.
interface pc_gen_ras_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] save_pc;
  logic             pred_taken;
  logic             is_call;
  logic             is_ret;
  logic [WIDTH-1:0] pred_target;

  logic [WIDTH-1:0] pc_add;
  logic [CNT_W-1:0] ras_count;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output stall, flush, save_pc, pred_taken, is_call, is_ret, pred_target,
    input  pc_add, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, flush, save_pc, pred_taken, is_call, is_ret, pred_target,
    output pc_add, ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_gen_ras.sv
// Registered fetch-PC generator with a circular return-address stack.
// Next-PC priority: flush > stall > return (stack non-empty) > call > taken > sequential.
module pc_gen_ras #(
  parameter int               WIDTH        = 32,
  parameter int               INC          = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4
) (
  input logic          clk,
  input logic          reset,
  pc_gen_ras_if.slave  bus
);

  localparam int               PTR_W = $clog2(RAS_DEPTH);
  localparam int               CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] STEP  = WIDTH'(INC);
  localparam logic [PTR_W-1:0] ONE   = PTR_W'(1);

  typedef enum logic [2:0] {
    SRC_FLUSH,
    SRC_HOLD,
    SRC_POP,
    SRC_CALL,
    SRC_TAKEN,
    SRC_SEQ
  } src_e;

  logic [WIDTH-1:0] r_pc;
  logic [PTR_W-1:0] r_ptr;       // next free slot; top of stack is r_ptr-1
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];

  src_e             w_src;
  logic [WIDTH-1:0] w_seq_pc;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_pc_next;
  logic [PTR_W-1:0] w_ptr_next;
  logic [CNT_W-1:0] w_count_next;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic             w_underflow_next;
  logic             w_overflow_next;

  assign w_seq_pc = r_pc + STEP;
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL);
  assign w_top    = r_ras[r_ptr - ONE];

  // An empty-stack return falls through to the call/taken/sequential choices.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_src = SRC_SEQ;
    if (bus.flush)                    w_src = SRC_FLUSH;
    else if (bus.stall)               w_src = SRC_HOLD;
    else if (bus.is_ret && !w_empty)  w_src = SRC_POP;
    else if (bus.is_call)             w_src = SRC_CALL;
    else if (bus.pred_taken)          w_src = SRC_TAKEN;
  end

  always_comb begin
    w_pc_next = w_seq_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    unique case (w_src)
      SRC_FLUSH: w_pc_next = bus.save_pc;
      SRC_HOLD:  w_pc_next = r_pc;
      SRC_POP: begin
        w_pc_next = w_top;
        w_pop     = 1'b1;
      end
      SRC_CALL: begin
        w_pc_next = bus.pred_target;
        w_push    = 1'b1;
      end
      SRC_TAKEN: w_pc_next = bus.pred_target;
      default:   w_pc_next = w_seq_pc;
    endcase
  end

  always_comb begin
    w_ptr_next   = r_ptr;
    w_count_next = r_count;
    if (w_push) begin
      w_ptr_next = r_ptr + ONE;
      if (!w_full) w_count_next = r_count + CNT_W'(1);
    end else if (w_pop) begin
      w_ptr_next   = r_ptr - ONE;
      w_count_next = r_count - CNT_W'(1);
    end
  end

  // A push into a full stack lands on the oldest slot, which is r_ptr itself.
  assign w_overflow_next  = r_overflow | (w_push & w_full);
  assign w_underflow_next = !bus.flush && !bus.stall && bus.is_ret && w_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= RESET_VECTOR;
      r_ptr       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_pc        <= w_pc_next;
      r_ptr       <= w_ptr_next;
      r_count     <= w_count_next;
      r_overflow  <= w_overflow_next;
      r_underflow <= w_underflow_next;
    end
  end

  // NOTE: stack storage has no reset; entries are unreachable while r_count is zero.
  always_ff @(posedge clk) begin
    if (w_push && reset) r_ras[r_ptr] <= w_seq_pc;
  end

  assign bus.pc_add        = r_pc;
  assign bus.ras_count     = r_count;
  assign bus.ras_overflow  = r_overflow;
  assign bus.ras_underflow = r_underflow;

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge clk) disable iff (!reset)
    r_count <= FULL);

  a_stall_holds : assert property (@(posedge clk) disable iff (!reset)
    (bus.stall && !bus.flush) |=> (r_pc == $past(r_pc)) && (r_count == $past(r_count)));

  a_flush_keeps_ras : assert property (@(posedge clk) disable iff (!reset)
    bus.flush |=> (r_count == $past(r_count)) && (r_ptr == $past(r_ptr)));
`endif

endmodule

// File: tb/tb_pc_gen_ras.sv
// Scoreboard bench for pc_gen_ras: a queue-based stack model predicts each
// edge's outputs, which are popped and compared one step after the edge.
module tb_pc_gen_ras;

  localparam int WIDTH = 32;
  localparam int INC   = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        ovf;
    logic        udf;
  } obs_t;

  typedef struct {
    logic        st;
    logic        fl;
    logic [31:0] sp;
    logic        tk;
    logic        cl;
    logic        rt;
    logic [31:0] tg;
  } stim_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  pc_gen_ras_if #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH)) bus ();

  pc_gen_ras #(
    .WIDTH(WIDTH), .INC(INC), .RESET_VECTOR(32'h0), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  obs_t        sb[$];
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];
  logic        m_ovf;

  function automatic obs_t observe();
    return {bus.pc_add, bus.ras_count, bus.ras_overflow, bus.ras_underflow};
  endfunction

  function automatic string show(input obs_t o);
    return $sformatf("pc=%h cnt=%0d ov=%b uf=%b", o.pc, o.cnt, o.ovf, o.udf);
  endfunction

  function automatic stim_t mk(input logic st, input logic fl, input logic [31:0] sp,
                               input logic tk, input logic cl, input logic rt,
                               input logic [31:0] tg);
    stim_t s;
    s.st = st; s.fl = fl; s.sp = sp; s.tk = tk; s.cl = cl; s.rt = rt; s.tg = tg;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(0, 0, 32'h0, 0, 0, 0, 32'h0);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    m_stack.delete();
    m_ovf = 1'b0;
    sb.delete();
  endtask

  // Applies one cycle of stimulus, predicts the post-edge outputs, and waits
  // until just after the edge so the caller can pop and compare.
  task automatic drive(input stim_t s);
    obs_t e;
    logic udf;
    bus.stall       = s.st;
    bus.flush       = s.fl;
    bus.save_pc     = s.sp;
    bus.pred_taken  = s.tk;
    bus.is_call     = s.cl;
    bus.is_ret      = s.rt;
    bus.pred_target = s.tg;
    udf = 1'b0;
    if (s.fl) begin
      m_pc = s.sp;
    end else if (s.st) begin
      m_pc = m_pc;
    end else if (s.rt && m_stack.size() > 0) begin
      m_pc = m_stack.pop_back();
    end else begin
      if (s.rt) udf = 1'b1;
      if (s.cl) begin
        if (m_stack.size() == DEPTH) begin
          void'(m_stack.pop_front());
          m_ovf = 1'b1;
        end
        m_stack.push_back(m_pc + 32'd4);
        m_pc = s.tg;
      end else if (s.tk) begin
        m_pc = s.tg;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    e.pc  = m_pc;
    e.cnt = 3'(m_stack.size());
    e.ovf = m_ovf;
    e.udf = udf;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t zero;
    obs_t got;
    zero = '0;
    bus.stall = 0; bus.flush = 0; bus.save_pc = 0; bus.pred_taken = 0;
    bus.is_call = 0; bus.is_ret = 0; bus.pred_target = 0;
    #3;
    got = observe();
    vectors++;
    if (got !== zero) begin
      miscompares++;
      $display("FAIL reset_initial: got %s expected %s", show(got), show(zero));
    end
    bus.flush = 1; bus.save_pc = 32'h1234; bus.is_call = 1; bus.pred_target = 32'h5678;
    @(posedge clk);
    #1;
    got = observe();
    vectors++;
    if (got !== zero) begin
      miscompares++;
      $display("FAIL reset_held_edge: got %s expected %s", show(got), show(zero));
    end
    @(negedge clk);
    bus.flush = 0; bus.save_pc = 0; bus.is_call = 0; bus.pred_target = 0;
    reset = 1'b1;
    model_reset();
    #1;
    got = observe();
    vectors++;
    if (got !== zero) begin
      miscompares++;
      $display("FAIL reset_release: got %s expected %s", show(got), show(zero));
    end
  endtask

  task automatic test_sequential();
    obs_t got, exp;
    for (int i = 0; i < 3; i++) begin
      drive(idle());
      got = observe();
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL sequential[%0d]: got %s expected %s", i, show(got), show(exp));
      end
    end
  endtask

  task automatic test_call_ret();
    stim_t v[$];
    obs_t  got, exp;
    v.push_back(mk(0, 1, 32'h100, 0, 0, 0, 32'h0));
    v.push_back(mk(0, 0, 32'h0,   0, 1, 0, 32'h400));
    v.push_back(idle());
    v.push_back(idle());
    v.push_back(mk(0, 0, 32'h0,   0, 0, 1, 32'h0));
    v.push_back(idle());
    foreach (v[i]) begin
      drive(v[i]);
      got = observe();
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL call_ret[%0d]: got %s expected %s", i, show(got), show(exp));
      end
      if (i == 4) begin
        vectors++;
        if (got.pc !== 32'h104) begin
          miscompares++;
          $display("FAIL call_ret_return_addr: got pc=%h expected pc=00000104", got.pc);
        end
      end
    end
  endtask

  task automatic test_overflow_underflow();
    stim_t v[$];
    obs_t  got, exp;
    v.push_back(mk(0, 1, 32'h10, 0, 0, 0, 32'h0));
    for (int k = 2; k <= 6; k++) v.push_back(mk(0, 0, 32'h0, 0, 1, 0, 32'(k * 16)));
    for (int k = 0; k < 5; k++)  v.push_back(mk(0, 0, 32'h0, 0, 0, 1, 32'h0));
    v.push_back(idle());
    v.push_back(idle());
    foreach (v[i]) begin
      drive(v[i]);
      got = observe();
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL overflow_underflow[%0d]: got %s expected %s", i, show(got), show(exp));
      end
    end
  endtask

  task automatic test_flush_priority();
    stim_t v[$];
    obs_t  got, exp;
    v.push_back(mk(0, 0, 32'h0,   0, 1, 0, 32'h700));
    v.push_back(mk(1, 1, 32'h800, 1, 1, 1, 32'h999));
    v.push_back(idle());
    foreach (v[i]) begin
      drive(v[i]);
      got = observe();
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL flush_priority[%0d]: got %s expected %s", i, show(got), show(exp));
      end
    end
  endtask

  task automatic test_stall_ret();
    stim_t v[$];
    obs_t  got, exp;
    v.push_back(mk(0, 0, 32'h0,   0, 0, 1, 32'h0));
    v.push_back(mk(0, 1, 32'h200, 0, 0, 0, 32'h0));
    v.push_back(mk(0, 0, 32'h0,   0, 1, 0, 32'h300));
    v.push_back(mk(0, 0, 32'h0,   0, 1, 0, 32'h500));
    for (int k = 0; k < 3; k++) v.push_back(mk(1, 0, 32'h0, 0, 0, 1, 32'h0));
    v.push_back(mk(0, 0, 32'h0,   0, 0, 1, 32'h0));
    v.push_back(idle());
    foreach (v[i]) begin
      drive(v[i]);
      got = observe();
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL stall_ret[%0d]: got %s expected %s", i, show(got), show(exp));
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t v[$];
    obs_t  got, exp;
    v.push_back(mk(0, 0, 32'h0,   0, 1, 1, 32'hA00));
    v.push_back(mk(0, 0, 32'h0,   0, 1, 1, 32'hB00));
    v.push_back(idle());
    v.push_back(mk(0, 0, 32'h0,   0, 0, 1, 32'h0));
    v.push_back(mk(1, 0, 32'h0,   0, 0, 1, 32'h0));
    v.push_back(mk(0, 1, 32'hC00, 0, 0, 1, 32'h0));
    v.push_back(idle());
    for (int k = 0; k < 80; k++) begin
      v.push_back(mk(($urandom % 8) == 0, ($urandom % 16) == 0, $urandom & 32'hFFFF_FFFC,
                     ($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
                     $urandom & 32'hFFFF_FFFC));
    end
    foreach (v[i]) begin
      drive(v[i]);
      got = observe();
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %s expected %s", i, show(got), show(exp));
      end
    end
  endtask

  task automatic test_wrap_async_reset();
    stim_t v[$];
    obs_t  got, exp, zero;
    zero = '0;
    v.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0));
    v.push_back(idle());
    v.push_back(mk(0, 0, 32'h0, 0, 1, 0, 32'h40));
    foreach (v[i]) begin
      drive(v[i]);
      got = observe();
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got %s expected %s", i, show(got), show(exp));
      end
      if (i == 1) begin
        vectors++;
        if (got.pc !== 32'h0) begin
          miscompares++;
          $display("FAIL wrap_to_zero: got pc=%h expected pc=00000000", got.pc);
        end
      end
    end
    bus.stall = 1; bus.flush = 1; bus.save_pc = 32'h900;
    #1;
    reset = 1'b0;
    #1;
    got = observe();
    vectors++;
    if (got !== zero) begin
      miscompares++;
      $display("FAIL async_reset_midcycle: got %s expected %s", show(got), show(zero));
    end
    #3;
    bus.stall = 0; bus.flush = 0; bus.save_pc = 0;
    reset = 1'b1;
    model_reset();
    #1;
    got = observe();
    vectors++;
    if (got !== zero) begin
      miscompares++;
      $display("FAIL async_reset_release: got %s expected %s", show(got), show(zero));
    end
    drive(idle());
    got = observe();
    exp = sb.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL first_edge_after_reset: got %s expected %s", show(got), show(exp));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_call_ret();
    test_overflow_underflow();
    test_flush_priority();
    test_stall_ret();
    test_back_to_back();
    test_wrap_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pc_gen_ras.md
PC_GEN_RAS -- requirements
Module: pc_gen_ras

Interface
REQ-001 Parameter WIDTH, 32, address width of all PC buses.
REQ-002 Parameter INC, 4, sequential PC increment in bytes.
REQ-003 Parameter RESET_VECTOR, 0, PC value loaded on reset.
REQ-004 Parameter RAS_DEPTH, 4, return-address-stack entries; power of two, ≥2.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 stall  in  1  hold PC and RAS this cycle.
REQ-008 flush  in  1  mispredict/recovery redirect request.
REQ-009 save_pc  in  WIDTH  redirect target used when flush=1.
REQ-010 pred_taken  in  1  predictor says current fetch is a taken branch.
REQ-011 is_call  in  1  current fetch predicted as call.
REQ-012 is_ret  in  1  current fetch predicted as return.
REQ-013 pred_target  in  WIDTH  predicted target for taken branch/call.
REQ-014 pc_add  out  WIDTH  current fetch address (registered).
REQ-015 ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
REQ-016 ras_overflow  out  1  sticky: a push overwrote an entry.
REQ-017 ras_underflow  out  1  one-cycle pulse: return seen with empty RAS.

Function
REQ-018 Next-PC priority per edge SHALL be: flush > stall > is_ret (RAS non-empty) > is_call > pred_taken > sequential.
REQ-019 flush=1: pc_add <= save_pc; RAS unchanged; stall, is_call, is_ret, pred_taken ignored.
REQ-020 stall=1, flush=0: pc_add, RAS contents, pointer and count SHALL hold; ras_underflow SHALL be 0.
REQ-021 is_ret=1, count>0: pc_add <= top entry; pointer decrements (mod RAS_DEPTH); count decrements.
REQ-022 is_ret=1, count=0: treated as not-ret; next PC by remaining priority (is_call, pred_taken, sequential); ras_underflow=1 next cycle.
REQ-023 is_call=1, not overridden: push pc_add+INC (mod 2^WIDTH); pc_add <= pred_target; pointer increments (mod RAS_DEPTH).
REQ-024 Push with count=RAS_DEPTH: oldest entry overwritten circularly; count stays RAS_DEPTH; ras_overflow set until reset.
REQ-025 is_call and is_ret both 1 with count>0: ret wins, single pop, no push.
REQ-026 pred_taken=1 only: pc_add <= pred_target; RAS unchanged.
REQ-027 Otherwise pc_add <= pc_add+INC, wrapping modulo 2^WIDTH with no flag.
REQ-028 Latency: any input affects pc_add exactly one rising edge later; no combinational input-to-output path.
REQ-029 ras_underflow SHALL be a registered single-cycle pulse, asserted only in cycle following an accepted (unstalled, unflushed) empty-RAS return.

Reset
REQ-030 reset=0 SHALL immediately (asynchronously) force pc_add=RESET_VECTOR, ras_count=0, pointer=0, ras_overflow=0, ras_underflow=0.
REQ-031 RAS entry storage need not be cleared; entries SHALL be unobservable while count=0.
REQ-032 First edge after reset deasserts SHALL apply normal priority (first update from RESET_VECTOR).
REQ-033 Reset asserted mid-operation (e.g. during stall or flush) SHALL override all inputs with no partial update.

Verification (WIDTH=32, INC=4, RESET_VECTOR=0, RAS_DEPTH=4)
REQ-034 Release reset, no requests, 3 edges -> pc_add 0x0,0x4,0x8,0xC.
REQ-035 At pc_add=0x100: is_call, pred_target=0x400 -> pc_add=0x400, count=1; later is_ret -> pc_add=0x104, count=0.
REQ-036 5 calls from 0x10,0x20,0x30,0x40,0x50 -> count=4, ras_overflow=1; 4 rets yield 0x54,0x44,0x34,0x24; 5th ret -> sequential PC, ras_underflow pulses 1 cycle.
REQ-037 flush=1, save_pc=0x800 with stall=1, is_call=1 same cycle -> pc_add=0x800, count unchanged.
REQ-038 stall=1 for 3 cycles with is_ret and count=2 -> pc_add and count held; on release pop occurs once.
REQ-039 At pc_add=0xFFFFFFFC sequential -> 0x0; assert reset asynchronously mid-cycle -> pc_add=0x0, count=0, flags 0 before next edge.
